// File: rtl/sram_controller.sv
// Bridges a 32-bit load/store pipeline port to a 16-bit asynchronous SRAM,
// splitting each word into a low and a high half-access of WAIT_CYCLES each.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] SRAM_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_r_en,
  input  logic        MEM_w_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic        last;
  logic [31:0] offset;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic        unused_offset_bits;

  assign req    = MEM_r_en | MEM_w_en;
  assign offset = address - SRAM_BASE;
  // Only the in-window word bits address the SRAM; everything else wraps.
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    last      = (cnt_q == LAST_CNT);
    ready     = !(req && (state_q != DONE));
    SRAM_WE_N = 1'b1;
    SRAM_ADDR = 18'd0;
    dq_oe     = 1'b0;
    dq_out    = 16'h0000;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = 4'd0;
          wr_d    = MEM_w_en;
          word_d  = offset[18:2];
          wdata_d = write_data;
        end
      end
      LO: begin
        SRAM_ADDR = {word_q, 1'b0};
        SRAM_WE_N = !wr_q;
        dq_oe     = wr_q;
        dq_out    = wdata_q[15:0];
        if (last) begin
          state_d = HI;
          cnt_d   = 4'd0;
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        SRAM_ADDR = {word_q, 1'b1};
        SRAM_WE_N = !wr_q;
        dq_oe     = wr_q;
        dq_out    = wdata_q[31:16];
        if (last) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
  assign read_data = rdata_q;
  assign SRAM_OE_N = ~SRAM_WE_N;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with the default WAIT_CYCLES=2 and a tiny
// read-only SRAM model that answers half-word addresses 2 and 3.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_r_en = 1'b0;
  logic        MEM_w_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] SRAM_DQ;
  wire  [17:0] SRAM_ADDR;
  wire         SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  logic        model_en = 1'b0;
  logic [15:0] model_val;

  int checks = 0;
  int errors = 0;

  // {ready, WE_N, OE_N, ADDR, DQ}
  wire  [36:0] bus = {ready, SRAM_WE_N, SRAM_OE_N, SRAM_ADDR, SRAM_DQ};
  logic [36:0] exp_bus;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_r_en   (MEM_r_en),
    .MEM_w_en   (MEM_w_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_OE_N  (SRAM_OE_N),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_UB_N  (SRAM_UB_N),
    .SRAM_LB_N  (SRAM_LB_N)
  );

  always #5 clk = ~clk;

  always_comb begin
    model_val = 16'h0000;
    if (SRAM_ADDR == 18'd2) model_val = 16'hBEEF;
    else if (SRAM_ADDR == 18'd3) model_val = 16'hDEAD;
  end

  assign SRAM_DQ = (model_en && SRAM_WE_N) ? model_val : 16'bz;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    exp_bus = {1'b1, 1'b1, 1'b0, 18'd0, 16'hzzzz};
    checks++;
    if (bus !== exp_bus) begin
      errors++;
      $display("FAIL reset_bus: got %h expected %h", bus, exp_bus);
    end
    checks++;
    if (read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_read_data: got %h expected %h", read_data, 32'd0);
    end
    checks++;
    if ({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_idle();
    exp_bus = {1'b1, 1'b1, 1'b0, 18'd0, 16'hzzzz};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL idle_bus cyc%0d: got %h expected %h", i, bus, exp_bus);
      end
    end
    $display("test_idle done");
  endtask

  task automatic test_write();
    MEM_w_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
    #1;
    exp_bus = {1'b0, 1'b1, 1'b0, 18'd0, 16'hzzzz};
    checks++;
    if (bus !== exp_bus) begin
      errors++;
      $display("FAIL write_idle: got %h expected %h", bus, exp_bus);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      exp_bus = (i < 2) ? {1'b0, 1'b0, 1'b1, 18'd2, 16'hBEEF}
                        : {1'b0, 1'b0, 1'b1, 18'd3, 16'hDEAD};
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL write_bus cyc%0d: got %h expected %h", i, bus, exp_bus);
      end
    end
    @(posedge clk);
    #1;
    exp_bus = {1'b1, 1'b1, 1'b0, 18'd0, 16'hzzzz};
    checks++;
    if (bus !== exp_bus) begin
      errors++;
      $display("FAIL write_done: got %h expected %h", bus, exp_bus);
    end
    MEM_w_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus !== exp_bus) begin
      errors++;
      $display("FAIL write_after: got %h expected %h", bus, exp_bus);
    end
    $display("test_write addr=1028 data=deadbeef done");
  endtask

  task automatic test_read();
    model_en = 1'b1;
    MEM_r_en = 1'b1; address = 32'd1028;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL read_idle_ready: got %b expected 0", ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      exp_bus = (i < 2) ? {1'b0, 1'b1, 1'b0, 18'd2, 16'hBEEF}
                        : {1'b0, 1'b1, 1'b0, 18'd3, 16'hDEAD};
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL read_bus cyc%0d: got %h expected %h", i, bus, exp_bus);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ready, SRAM_WE_N} !== 2'b11) begin
      errors++;
      $display("FAIL read_done_ready: got %b expected 11", {ready, SRAM_WE_N});
    end
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_data: got %h expected %h", read_data, 32'hDEADBEEF);
    end
    MEM_r_en = 1'b0;
    model_en = 1'b0;
    @(posedge clk);
    #1;
    $display("test_read addr=1028 data=%h done", read_data);
  endtask

  task automatic test_both();
    MEM_r_en = 1'b1; MEM_w_en = 1'b1; address = 32'd1024; write_data = 32'h00010002;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      exp_bus = (i < 2) ? {1'b0, 1'b0, 1'b1, 18'd0, 16'h0002}
                        : {1'b0, 1'b0, 1'b1, 18'd1, 16'h0001};
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL both_bus cyc%0d: got %h expected %h", i, bus, exp_bus);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL both_read_data: got %h expected %h", read_data, 32'hDEADBEEF);
    end
    MEM_r_en = 1'b0; MEM_w_en = 1'b0;
    @(posedge clk);
    #1;
    $display("test_both addr=1024 done");
  endtask

  task automatic test_deassert();
    MEM_w_en = 1'b1; address = 32'd1036; write_data = 32'h12345678;
    @(posedge clk);
    #1;
    exp_bus = {1'b0, 1'b0, 1'b1, 18'd6, 16'h5678};
    checks++;
    if (bus !== exp_bus) begin
      errors++;
      $display("FAIL deassert_first: got %h expected %h", bus, exp_bus);
    end
    MEM_w_en = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      exp_bus = (i < 2) ? {1'b1, 1'b0, 1'b1, 18'd6, 16'h5678}
                        : {1'b1, 1'b0, 1'b1, 18'd7, 16'h1234};
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL deassert_bus cyc%0d: got %h expected %h", i, bus, exp_bus);
      end
    end
    exp_bus = {1'b1, 1'b1, 1'b0, 18'd0, 16'hzzzz};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL deassert_tail cyc%0d: got %h expected %h", i, bus, exp_bus);
      end
    end
    $display("test_deassert addr=1036 done");
  endtask

  task automatic test_reset_mid();
    MEM_w_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    exp_bus = {1'b0, 1'b0, 1'b1, 18'd5, 16'hCAFE};
    checks++;
    if (bus !== exp_bus) begin
      errors++;
      $display("FAIL rstmid_hi: got %h expected %h", bus, exp_bus);
    end
    rst = 1'b1;
    #1;
    exp_bus = {1'b0, 1'b1, 1'b0, 18'd0, 16'hzzzz};
    checks++;
    if (bus !== exp_bus) begin
      errors++;
      $display("FAIL rstmid_now: got %h expected %h", bus, exp_bus);
    end
    checks++;
    if (read_data !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_read_data: got %h expected %h", read_data, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus !== exp_bus) begin
      errors++;
      $display("FAIL rstmid_release: got %h expected %h", bus, exp_bus);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      exp_bus = (i < 2) ? {1'b0, 1'b0, 1'b1, 18'd4, 16'hF00D}
                        : {1'b0, 1'b0, 1'b1, 18'd5, 16'hCAFE};
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL rstmid_bus cyc%0d: got %h expected %h", i, bus, exp_bus);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_done_ready: got %b expected 1", ready);
    end
    MEM_w_en = 1'b0;
    @(posedge clk);
    #1;
    $display("test_reset_mid addr=1032 done");
  endtask

  task automatic test_back_to_back();
    logic [17:0] base;
    logic [31:0] data;
    MEM_w_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
    for (int k = 0; k < 2; k++) begin
      base = (k == 0) ? 18'd0 : 18'd4;
      data = (k == 0) ? 32'h11112222 : 32'h33334444;
      #1;
      exp_bus = {1'b0, 1'b1, 1'b0, 18'd0, 16'hzzzz};
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL b2b_idle acc%0d: got %h expected %h", k, bus, exp_bus);
      end
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        exp_bus = (i < 2) ? {1'b0, 1'b0, 1'b1, base, data[15:0]}
                          : {1'b0, 1'b0, 1'b1, base + 18'd1, data[31:16]};
        checks++;
        if (bus !== exp_bus) begin
          errors++;
          $display("FAIL b2b_bus acc%0d cyc%0d: got %h expected %h", k, i, bus, exp_bus);
        end
      end
      @(posedge clk);
      #1;
      exp_bus = {1'b1, 1'b1, 1'b0, 18'd0, 16'hzzzz};
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL b2b_done acc%0d: got %h expected %h", k, bus, exp_bus);
      end
      if (k == 0) begin
        address = 32'd1032; write_data = 32'h33334444;
      end else begin
        MEM_w_en = 1'b0;
      end
      @(posedge clk);
      $display("test_back_to_back access %0d done", k);
    end
    exp_bus = {1'b1, 1'b1, 1'b0, 18'd0, 16'hzzzz};
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus !== exp_bus) begin
        errors++;
        $display("FAIL b2b_tail cyc%0d: got %h expected %h", i, bus, exp_bus);
      end
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_both();
    test_deassert();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
